// File: rtl/hls_clock_pkg.sv
// Shared definitions for the microsecond-clock command/response protocol.
// The command encodings are also used by the clock responder side.
package hls_clock_pkg;

  localparam int DEFAULT_RSP_WIDTH = 64;

  // Command encodings carried in the CMD FIFO word
  localparam logic CMD_CLOCK_RESET  = 1'b0;
  localparam logic CMD_CLOCK_SAMPLE = 1'b1;

  // Client FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/hls_clock_client_if.sv
// Bundle of request, CMD FIFO, RSP FIFO and result signals for the clock client.
// master = the client itself, slave = the surrounding logic / FIFOs.
interface hls_clock_client_if #(
  parameter int CMD_WIDTH = 1,
  parameter int RSP_WIDTH = hls_clock_pkg::DEFAULT_RSP_WIDTH
);
  logic                 REQ_RESET;
  logic                 REQ_SAMPLE;
  logic                 REQ_READY;
  logic [CMD_WIDTH-1:0] CMD_DATA;
  logic                 CMD_WREN;
  logic                 CMD_FULL_N;
  logic [RSP_WIDTH-1:0] RSP_DATA;
  logic                 RSP_EMPTY_N;
  logic                 RSP_RDEN;
  logic [RSP_WIDTH-1:0] TIMESTAMP;
  logic [RSP_WIDTH-1:0] ELAPSED;
  logic                 RESULT_VALID;
  logic                 TIMEOUT_ERR;

  modport master (
    input  REQ_RESET, REQ_SAMPLE, CMD_FULL_N, RSP_DATA, RSP_EMPTY_N,
    output REQ_READY, CMD_DATA, CMD_WREN, RSP_RDEN,
           TIMESTAMP, ELAPSED, RESULT_VALID, TIMEOUT_ERR
  );

  modport slave (
    output REQ_RESET, REQ_SAMPLE, CMD_FULL_N, RSP_DATA, RSP_EMPTY_N,
    input  REQ_READY, CMD_DATA, CMD_WREN, RSP_RDEN,
           TIMESTAMP, ELAPSED, RESULT_VALID, TIMEOUT_ERR
  );

endinterface

// File: rtl/hls_clock_client.sv
// Initiator end of the microsecond-clock command/response FIFO protocol.
// One command outstanding at a time; stale responses are drained before a
// new request is taken so every response pairs with the command just sent.
module hls_clock_client
  import hls_clock_pkg::*;
#(
  parameter int CMD_WIDTH      = 1,
  parameter int RSP_WIDTH      = DEFAULT_RSP_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               CLK,
  input logic               RESET,
  hls_clock_client_if.master bus
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [CMD_WIDTH-1:0] cmd_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [RSP_WIDTH-1:0] timestamp_reg;
  logic [RSP_WIDTH-1:0] elapsed_reg;
  logic [RSP_WIDTH-1:0] prev_reg;
  logic                 valid_reg;
  logic                 err_reg;

  logic                 req_any;
  logic                 accept;
  logic                 pop;
  logic                 busy;
  logic                 timeout_hit;

  logic                 req_ready;
  logic                 cmd_wren;
  logic                 rsp_rden;

  assign req_any     = bus.REQ_RESET | bus.REQ_SAMPLE;
  assign accept      = (state_reg == IDLE) && !bus.RSP_EMPTY_N && req_any;
  assign pop         = (state_reg == WAIT) && bus.RSP_EMPTY_N;
  assign busy        = (state_reg == SEND) || (state_reg == WAIT);
  // A pop in the limit cycle takes priority over the abort
  assign timeout_hit = busy && (cnt_reg == LIMIT) && !pop;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.RSP_EMPTY_N) begin
          state_next = DRAIN;
        end else if (req_any) begin
          state_next = SEND;
        end
      end
      // One pop (or none if the flag already dropped), then re-check from IDLE
      DRAIN: state_next = IDLE;
      SEND: begin
        if (timeout_hit) begin
          state_next = IDLE;
        end else if (bus.CMD_FULL_N) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (pop || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO handshake and ready outputs, decoded from the current state
  always_comb begin
    req_ready = 1'b0;
    cmd_wren  = 1'b0;
    rsp_rden  = 1'b0;
    case (state_reg)
      IDLE:    req_ready = !bus.RSP_EMPTY_N;
      DRAIN:   rsp_rden  = bus.RSP_EMPTY_N;
      SEND:    cmd_wren  = bus.CMD_FULL_N;
      WAIT:    rsp_rden  = bus.RSP_EMPTY_N;
      default: ;
    endcase
  end

  // Command latch, timeout counter and result registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_reg       <= '0;
      cnt_reg       <= '0;
      timestamp_reg <= '0;
      elapsed_reg   <= '0;
      prev_reg      <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (accept) begin
        // Reset request wins over a simultaneous sample request
        cmd_reg <= bus.REQ_RESET ? CMD_WIDTH'(CMD_CLOCK_RESET)
                                 : CMD_WIDTH'(CMD_CLOCK_SAMPLE);
        cnt_reg <= '0;
      end else if (busy) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (pop) begin
        timestamp_reg <= bus.RSP_DATA;
        elapsed_reg   <= bus.RSP_DATA - prev_reg;
        prev_reg      <= bus.RSP_DATA;
        valid_reg     <= 1'b1;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.REQ_READY    = req_ready;
  assign bus.CMD_DATA     = cmd_reg;
  assign bus.CMD_WREN     = cmd_wren;
  assign bus.RSP_RDEN     = rsp_rden;
  assign bus.TIMESTAMP    = timestamp_reg;
  assign bus.ELAPSED      = elapsed_reg;
  assign bus.RESULT_VALID = valid_reg;
  assign bus.TIMEOUT_ERR  = err_reg;

endmodule
